// File: rtl/hi_lo_unit_pkg.sv
// Shared definitions for the HI/LO result stage: op and state encodings and
// the signed-to-unsigned product correction.
package hi_lo_unit_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MTHI  = 3'd3;
   localparam logic [2:0] OP_MTLO  = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Turns a signed 32x32 product into the unsigned one, modulo 2^64.
   // A set operand sign bit is worth 2^32 more as unsigned, so the other
   // operand is added in once, shifted up by 32.
   function automatic logic [63:0] correct_unsigned(input logic [63:0] p_s,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
      logic [63:0] add_a;
      logic [63:0] add_b;
      add_a = a[31] ? {b, 32'b0} : 64'b0;
      add_b = b[31] ? {a, 32'b0} : 64'b0;
      return p_s + add_a + add_b;
   endfunction

endpackage

// File: rtl/Multiplier_32.sv
// Signed 32x32 -> 64 product source feeding the HI/LO stage.
module Multiplier_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] prod;

   assign a_ext = {{32{a[31]}}, a};
   assign b_ext = {{32{b[31]}}, b};
   assign prod  = a_ext * b_ext;
   assign p     = prod;

endmodule

// File: rtl/hi_lo_unit.sv
// HI/LO result stage: latches operands on issue, holds a fixed busy window
// while the multiplier settles, then commits the (corrected) product to HI/LO.
module hi_lo_unit
   import hi_lo_unit_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_req,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [1:0]  dbg_state
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic               uns_q, uns_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [63:0]        prod_s;
   logic [63:0]        result;

   // Multiplier only ever sees the latched operands, so A/B may change freely
   // once the issue edge has passed.
   Multiplier_32 u_mult (
      .a (a_q),
      .b (b_q),
      .p (prod_s)
   );

   assign result = uns_q ? correct_unsigned(prod_s, a_q, b_q) : prod_s;

   // Issue handshake: start is taken on any edge where busy is low (IDLE or
   // DONE); while busy, start is dropped and the issuer must hold off.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      uns_d   = uns_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_BUSY: begin
            if (cnt_q == '0) begin
               hi_d    = result[63:32];
               lo_d    = result[31:0];
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d  = cnt_q - 1'b1;
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     a_d     = A;
                     b_d     = B;
                     uns_d   = (op == OP_MULTU);
                     cnt_d   = CNT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         uns_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         uns_q   <= uns_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign rd_data   = rd_sel ? hi_q : lo_q;
   assign stall     = rd_req & busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed and randomized bench for hi_lo_unit against an arithmetic model.
module tb_hi_lo_unit;
   import hi_lo_unit_pkg::*;

   localparam int LAT = 4;
   localparam logic [2:0] T_MULT  = 3'd1;
   localparam logic [2:0] T_MULTU = 3'd2;
   localparam logic [2:0] T_MTHI  = 3'd3;
   localparam logic [2:0] T_MTLO  = 3'd4;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        start, rd_req, rd_sel;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [31:0] rd_data, hi, lo;
   logic        stall, busy, done;
   logic [1:0]  dbg;

   logic        start1, rd_req1, rd_sel1;
   logic [2:0]  op1;
   logic [31:0] a1, b1;
   logic [31:0] rd_data1, hi1, lo1;
   logic        stall1, busy1, done1;
   logic [1:0]  dbg1;

   hi_lo_unit #(.LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
      .busy(busy), .done(done), .HI(hi), .LO(lo), .dbg_state(dbg)
   );

   hi_lo_unit #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .A(a1), .B(b1),
      .rd_req(rd_req1), .rd_sel(rd_sel1), .rd_data(rd_data1), .stall(stall1),
      .busy(busy1), .done(done1), .HI(hi1), .LO(lo1), .dbg_state(dbg1)
   );

   // scoreboard
   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi, m_lo;
   logic [63:0] exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
      longint sx, sy;
      if (o == T_MULTU) return {32'b0, x} * {32'b0, y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   // driver tasks; all run from a negedge and end on a negedge
   task automatic do_mul(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] e;
      start = 1'b1; op = o; a = x; b = y;
      exp_q.push_back(ref_prod(o, x, y));
      @(negedge clk);
      start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
      for (int i = 0; i < LAT; i++) begin
         chk("mul_busy", busy, 1'b1);
         chk("mul_nodone", done, 1'b0);
         chk("mul_hold", {hi, lo}, {m_hi, m_lo});
         @(negedge clk);
      end
      chk("mul_busy_off", busy, 1'b0);
      chk("mul_done", done, 1'b1);
      if (exp_q.size() == 0) begin
         chk("mul_queue", 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk("mul_result", {hi, lo}, e);
         m_hi = e[63:32];
         m_lo = e[31:0];
      end
   endtask

   task automatic idle_step();
      @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
   endtask

   task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
      start = 1'b1; op = o; a = x; b = $urandom;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      if (o == T_MTHI) m_hi = x; else m_lo = x;
      chk("mt_regs", {hi, lo}, {m_hi, m_lo});
      chk("mt_busy", busy, 1'b0);
      chk("mt_done", done, 1'b0);
      rd_sel = (o == T_MTHI);
      #1 chk("mt_rd", rd_data, x);
   endtask

   task automatic do_nop(input logic [2:0] o);
      start = 1'b1; op = o; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("nop_regs", {hi, lo}, {m_hi, m_lo});
      chk("nop_busy", busy, 1'b0);
      chk("nop_done", done, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; rd_req = 1'b0; rd_sel = 1'b0;
      start1 = 1'b0; op1 = 3'd0; a1 = '0; b1 = '0; rd_req1 = 1'b0; rd_sel1 = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      chk("rst_regs", {hi, lo}, 64'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_state", dbg, S_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // basic signed multiply
      do_mul(T_MULT, 32'd14, 32'd3);
      chk("t1_const", {hi, lo}, 64'h0000_0000_0000_002A);
      idle_step();

      // negative operands, second issued in the DONE cycle
      do_mul(T_MULT, 32'hFFFF_FFC9, 32'hFFFF_FFF6);
      chk("t2a_const", {hi, lo}, 64'd550);
      do_mul(T_MULT, 32'd100, 32'hFFFF_FFEC);
      chk("t2b_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_F830);
      idle_step();

      // unsigned correction vs signed
      do_mul(T_MULTU, 32'hFFFF_FFFF, 32'd2);
      chk("t3u_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      do_mul(T_MULT, 32'hFFFF_FFFF, 32'd2);
      chk("t3s_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      idle_step();

      // start and read while busy
      start = 1'b1; op = T_MULT; a = 32'd7; b = 32'd6;
      @(negedge clk);
      op = T_MTHI; a = 32'h1234; rd_req = 1'b1; rd_sel = 1'b1;
      #1 chk("t4_stall", stall, 1'b1);
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("t4_busy", busy, 1'b1);
      chk("t4_hi_hold", hi, m_hi);
      repeat (LAT - 1) @(negedge clk);
      chk("t4_done", done, 1'b1);
      chk("t4_stall_off", stall, 1'b0);
      rd_sel = 1'b0;
      #1 chk("t4_rd_lo", rd_data, 32'd42);
      chk("t4_hi", hi, 32'd0);
      m_hi = 32'd0; m_lo = 32'd42;
      rd_req = 1'b0;
      idle_step();

      // moves from idle
      do_mt(T_MTHI, 32'hDEAD_BEEF);
      do_mt(T_MTLO, 32'h1);
      chk("t5_const", {hi, lo}, 64'hDEAD_BEEF_0000_0001);
      idle_step();

      // randomized traffic
      repeat (30) begin
         logic [2:0] o;
         o = 3'($urandom_range(0, 7));
         case (o)
            T_MULT, T_MULTU: do_mul(o, $urandom, $urandom);
            T_MTHI, T_MTLO:  do_mt(o, $urandom);
            default:         do_nop(o);
         endcase
         if ($urandom_range(0, 1) == 1) idle_step();
      end
      idle_step();

      // reset abort mid-multiply
      do_mt(T_MTHI, 32'd5);
      do_mt(T_MTLO, 32'd5);
      start = 1'b1; op = T_MULT; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_regs", {hi, lo}, 64'd0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
      exp_q.delete();
      repeat (LAT + 3) begin
         @(negedge clk);
         chk("t6_no_commit", {hi, lo}, 64'd0);
         chk("t6_no_busy", busy, 1'b0);
         chk("t6_no_done", done, 1'b0);
      end

      // single-cycle latency instance
      start1 = 1'b1; op1 = T_MULT; a1 = 32'd5; b1 = 32'hFFFF_FFFD;
      @(negedge clk);
      start1 = 1'b0; op1 = 3'd0;
      chk("l1_busy", busy1, 1'b1);
      chk("l1_nodone", done1, 1'b0);
      @(negedge clk);
      chk("l1_busy_off", busy1, 1'b0);
      chk("l1_done", done1, 1'b1);
      chk("l1_result", {hi1, lo1}, ref_prod(T_MULT, 32'd5, 32'hFFFF_FFFD));
      chk("l1_const", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFF1);
      @(negedge clk);
      chk("l1_done_off", done1, 1'b0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
